sha256_msg_schedule: RTL and testbench

// - Word-serial SHA-256 message-schedule expander; sits directly upstream of Generator.
// - Accepts the 16 words W0..W15 of one 512-bit block and emits W0..W63, one word per round, tagged with the round index.
// - Generator consumes w_word on its wordIn input and w_round on its counter input.

---
 rtl/sha256_msg_schedule_pkg.sv | 49 ++++
 rtl/sha256_msg_schedule_small_sigma.sv | 18 +
 rtl/sha256_msg_schedule.sv | 135 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared types, widths and sigma/carry-save helpers for the SHA-256 message schedule.
package sha256_msg_schedule_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WIN_DEPTH = 16;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned ROUND_W   = 6;

    localparam int unsigned S0_R1 = 7;
    localparam int unsigned S0_R2 = 18;
    localparam int unsigned S0_SH = 3;
    localparam int unsigned S1_R1 = 17;
    localparam int unsigned S1_R2 = 19;
    localparam int unsigned S1_SH = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Redundant (sum, carry) pair produced by one 3:2 compression stage
    typedef struct packed {
        word_t s;
        word_t c;
    } csa_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // Carry-save stage; the carry out of bit 31 is dropped (mod 2^32)
    function automatic csa_t csa(input word_t a, input word_t b, input word_t c);
        csa_t r;
        r.s = a ^ b ^ c;
        r.c = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_small_sigma.sv
// Combinational SHA-256 small sigma: SEL=0 selects sigma0, SEL=1 selects sigma1.
module sha256_msg_schedule_small_sigma
    import sha256_msg_schedule_pkg::*;
#(
    parameter int unsigned SEL = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    // Pick the rotate/shift set at elaboration time
    if (SEL == 0) begin : g_sigma0
        assign y = small_sigma0(x);
    end else begin : g_sigma1
        assign y = small_sigma1(x);
    end

endmodule

// File: rtl/sha256_msg_schedule.sv
// Word-serial SHA-256 message schedule: loads W0..W15, then expands W16..W(ROUNDS-1).
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_word,
    output logic [ROUND_W-1:0] w_round,
    output logic               w_last
);

    localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(WIN_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    state_e                           state;
    state_e                           state_nxt;
    logic [CNT_W-1:0]                 cnt;
    logic [WIN_DEPTH-1:0][WORD_W-1:0] win;

    logic  adv;
    logic  load_fire;
    logic  exp_fire;
    logic  shift_en;
    word_t new_word;
    word_t sig0;
    word_t sig1;
    csa_t  stage1;
    csa_t  stage2;
    word_t exp_word;

    assign adv = !w_valid || w_ready;

    sha256_msg_schedule_small_sigma #(.SEL(0)) u_sigma0 (
        .x (win[1]),
        .y (sig0)
    );

    sha256_msg_schedule_small_sigma #(.SEL(1)) u_sigma1 (
        .x (win[14]),
        .y (sig1)
    );

    // Four-operand sum: two carry-save stages then a single carry-propagate add
    assign stage1   = csa(sig1, win[9], sig0);
    assign stage2   = csa(stage1.s, stage1.c, win[0]);
    assign exp_word = stage2.s + stage2.c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: flush wins, otherwise advance at the load/expand boundaries
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:   if (load_fire && cnt == LOAD_END) state_nxt = ST_EXPAND;
                ST_EXPAND: if (exp_fire && cnt == LAST_CNT) state_nxt = ST_LOAD;
                default:   state_nxt = ST_LOAD;
            endcase
        end
    end

    // Handshake and shift enables decoded from state
    always_comb begin
        in_ready  = 1'b0;
        load_fire = 1'b0;
        exp_fire  = 1'b0;
        new_word  = exp_word;
        if (state == ST_LOAD) begin
            in_ready  = adv && !flush;
            load_fire = in_ready && in_valid;
            new_word  = in_word;
        end else begin
            exp_fire  = adv && !flush;
        end
        shift_en = load_fire || exp_fire;
    end

    // Round counter with explicit wrap at the final round
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Sliding window: win[15] newest, win[0] dropped on every shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (shift_en && !flush) begin
            win <= {new_word, win[WIN_DEPTH-1:1]};
        end
    end

    // Output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid <= 1'b0;
            w_word  <= '0;
            w_round <= '0;
            w_last  <= 1'b0;
        end else if (flush) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else if (shift_en) begin
            w_valid <= 1'b1;
            w_word  <= new_word;
            w_round <= ROUND_W'(cnt);
            w_last  <= (cnt == LAST_CNT);
        end else if (adv) begin
            w_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a direct-formula schedule model.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_round;
    logic        w_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg   [0:31];
    logic [31:0] exp_w [0:127];

    logic        o_ir;
    logic        o_v;
    logic [31:0] o_w;
    logic [5:0]  o_r;
    logic        o_l;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_word   (w_word),
        .w_round  (w_round),
        .w_last   (w_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Reference: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] per block
    task automatic build_expected(input int nblk);
        logic [31:0] w [0:63];
        for (int b = 0; b < nblk; b++) begin
            for (int t = 0; t < 16; t++) w[t] = msg[16*b + t];
            for (int t = 16; t < 64; t++)
                w[t] = m_s1(w[t-2]) + w[t-7] + m_s0(w[t-15]) + w[t-16];
            for (int t = 0; t < 64; t++) exp_w[64*b + t] = w[t];
        end
    endtask

    task automatic load_abc(input int nblk);
        for (int b = 0; b < nblk; b++) begin
            for (int t = 0; t < 16; t++) msg[16*b + t] = 32'h0;
            msg[16*b]      = 32'h61626380;
            msg[16*b + 15] = 32'h00000018;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then snapshot outputs
    task automatic drive_cycle(input logic iv, input logic [31:0] iw,
                               input logic wr, input logic fl);
        @(negedge clk);
        in_valid = iv;
        in_word  = iw;
        w_ready  = wr;
        flush    = fl;
        #1;
        o_ir = in_ready;
        o_v  = w_valid;
        o_w  = w_word;
        o_r  = w_round;
        o_l  = w_last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (w_valid !== 1'b0 || w_word !== 32'h0 || w_round !== 6'h0 || w_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v=%b w=%h r=%0d l=%b exp all zero", w_valid, w_word, w_round, w_last);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b exp 1", in_ready);
        end
    endtask

    task automatic test_abc_block();
        int idx = 0;
        int k = 0;
        int first = -1;
        load_abc(1);
        build_expected(1);
        for (int cyc = 0; cyc < 200 && k < 64; cyc++) begin
            drive_cycle(idx < 16, (idx < 16) ? msg[idx] : 32'h0, 1'b1, 1'b0);
            if (idx < 16 && o_ir) idx++;
            if (o_v) begin
                if (first < 0) first = cyc;
                checks++;
                if (o_r !== 6'(k) || o_w !== exp_w[k] || o_l !== (k == 63)) begin
                    errors++;
                    $display("FAIL abc_word: t=%0d got r=%0d w=%h l=%b exp r=%0d w=%h l=%b",
                             k, o_r, o_w, o_l, k, exp_w[k], (k == 63));
                end
                checks++;
                if (cyc - first != k) begin
                    errors++;
                    $display("FAIL abc_contig: t=%0d got cycle %0d exp %0d", k, cyc - first, k);
                end
                if (k == 16 || k == 17 || k == 63) begin
                    checks++;
                    if (o_w !== ((k == 16) ? 32'h61626380 : (k == 17) ? 32'h000F0000 : 32'h12B1EDEB)) begin
                        errors++;
                        $display("FAIL abc_known: t=%0d got %h", k, o_w);
                    end
                end
                k++;
            end
        end
        checks++;
        if (k != 64) begin
            errors++;
            $display("FAIL abc_timeout: got %0d words exp 64", k);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int k = 0;
        int first = -1;
        load_abc(2);
        build_expected(2);
        for (int cyc = 0; cyc < 300 && k < 128; cyc++) begin
            drive_cycle(idx < 32, (idx < 32) ? msg[idx] : 32'h0, 1'b1, 1'b0);
            if (idx < 32 && o_ir) idx++;
            if (o_v) begin
                if (first < 0) first = cyc;
                checks++;
                if (o_r !== 6'(k % 64) || o_w !== exp_w[k] || o_l !== (k % 64 == 63)
                    || cyc - first != k) begin
                    errors++;
                    $display("FAIL b2b_word: n=%0d got r=%0d w=%h l=%b cyc=%0d exp r=%0d w=%h cyc=%0d",
                             k, o_r, o_w, o_l, cyc - first, k % 64, exp_w[k], k);
                end
                k++;
            end
        end
        checks++;
        if (k != 128) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d words exp 128", k);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int k = 0;
        logic wr;
        logic stall;
        logic prev_stall = 1'b0;
        logic [31:0] prev_w = '0;
        logic [5:0]  prev_r = '0;
        load_abc(1);
        build_expected(1);
        for (int cyc = 0; cyc < 1000 && k < 64; cyc++) begin
            wr = 1'($urandom_range(0, 1));
            drive_cycle(idx < 16, (idx < 16) ? msg[idx] : 32'h0, wr, 1'b0);
            if (prev_stall) begin
                checks++;
                if (o_v !== 1'b1 || o_w !== prev_w || o_r !== prev_r) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b w=%h r=%0d exp v=1 w=%h r=%0d",
                             o_v, o_w, o_r, prev_w, prev_r);
                end
            end
            stall = o_v && !wr;
            if (stall) begin
                checks++;
                if (o_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready: got %b exp 0", o_ir);
                end
            end
            if (idx < 16 && o_ir) idx++;
            if (o_v && wr) begin
                checks++;
                if (o_r !== 6'(k) || o_w !== exp_w[k] || o_l !== (k == 63)) begin
                    errors++;
                    $display("FAIL bp_word: t=%0d got r=%0d w=%h exp w=%h", k, o_r, o_w, exp_w[k]);
                end
                k++;
            end
            prev_stall = stall;
            prev_w     = o_w;
            prev_r     = o_r;
        end
        checks++;
        if (k != 64) begin
            errors++;
            $display("FAIL bp_timeout: got %0d words exp 64", k);
        end
    endtask

    task automatic test_flush();
        int idx = 0;
        int k = 0;
        load_abc(1);
        build_expected(1);
        for (int cyc = 0; cyc < 200 && k < 20; cyc++) begin
            drive_cycle(idx < 16, (idx < 16) ? msg[idx] : 32'h0, 1'b1, 1'b0);
            if (idx < 16 && o_ir) idx++;
            if (o_v) k++;
        end
        drive_cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        checks++;
        if (o_v !== 1'b1 || o_r !== 6'd20 || o_ir !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got v=%b r=%0d ir=%b exp v=1 r=20 ir=0", o_v, o_r, o_ir);
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_v !== 1'b0 || o_ir !== 1'b1 || o_l !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got v=%b ir=%b l=%b exp v=0 ir=1 l=0", o_v, o_ir, o_l);
        end
        test_abc_block();
    endtask

    task automatic test_async_reset();
        int idx = 0;
        int k = 0;
        load_abc(1);
        build_expected(1);
        for (int cyc = 0; cyc < 200 && k < 40; cyc++) begin
            drive_cycle(idx < 16, (idx < 16) ? msg[idx] : 32'h0, 1'b1, 1'b0);
            if (idx < 16 && o_ir) idx++;
            if (o_v) k++;
        end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_v !== 1'b1 || o_r !== 6'd40) begin
            errors++;
            $display("FAIL arst_pre: got v=%b r=%0d exp v=1 r=40", o_v, o_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || w_word !== 32'h0 || w_round !== 6'h0 || w_last !== 1'b0) begin
            errors++;
            $display("FAIL arst_out: got v=%b w=%h r=%0d l=%b exp all zero", w_valid, w_word, w_round, w_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_in_ready: got %b exp 1", in_ready);
        end
        test_abc_block();
    endtask

    // Random words with random input gaps; bubbles must mirror the gaps during load
    task automatic test_gaps_random();
        int idx = 0;
        int k = 0;
        int acc_in_blk = 0;
        int exp_left = 0;
        logic iv;
        logic acc;
        logic prev_load = 1'b0;
        logic prev_acc = 1'b0;
        for (int i = 0; i < 32; i++) msg[i] = $urandom;
        build_expected(2);
        for (int cyc = 0; cyc < 600 && k < 128; cyc++) begin
            iv = (idx < 32) && ($urandom_range(0, 2) != 0);
            drive_cycle(iv, iv ? msg[idx] : 32'h0, 1'b1, 1'b0);
            if (prev_load) begin
                checks++;
                if (o_v !== prev_acc) begin
                    errors++;
                    $display("FAIL gap_bubble: cyc=%0d got v=%b exp %b", cyc, o_v, prev_acc);
                end
            end
            acc = 1'b0;
            if (exp_left > 0) begin
                checks++;
                if (o_ir !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_ready_exp: got %b exp 0", o_ir);
                end
                exp_left--;
                if (exp_left == 0) acc_in_blk = 0;
                prev_load = 1'b0;
            end else begin
                checks++;
                if (o_ir !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_ready_load: got %b exp 1", o_ir);
                end
                acc = iv;
                if (acc) begin
                    idx++;
                    acc_in_blk++;
                    if (acc_in_blk == 16) exp_left = 48;
                end
                prev_load = 1'b1;
            end
            prev_acc = acc;
            if (o_v) begin
                checks++;
                if (o_r !== 6'(k % 64) || o_w !== exp_w[k] || o_l !== (k % 64 == 63)) begin
                    errors++;
                    $display("FAIL gap_word: n=%0d got r=%0d w=%h exp r=%0d w=%h",
                             k, o_r, o_w, k % 64, exp_w[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 128) begin
            errors++;
            $display("FAIL gap_timeout: got %0d words exp 128", k);
        end
    endtask

    initial begin
        test_reset();
        test_abc_block();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_gaps_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
